// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: the scan-out reader always wins; the two pixel writers
// share the leftover cycles round-robin, and a saturating counter flags writer starvation.
module vga_fb_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 12,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr0_req,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ack,
    input  logic              wr1_req,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              starve
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    logic             wr0_gnt;
    logic             wr1_gnt;
    logic             rr_ptr;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_nxt;
    logic             vld_p0;
    logic             vld_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == WAIT_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        wr0_gnt  = 1'b0;
        wr1_gnt  = 1'b0;
        wait_nxt = wait_cnt;
        if (!rd_req) begin
            // When both writers ask, rr_ptr picks; otherwise the lone requester wins.
            wr0_gnt = wr0_req && (!wr1_req || !rr_ptr);
            wr1_gnt = wr1_req && (!wr0_req ||  rr_ptr);
        end
        if (wr0_gnt || wr1_gnt)
            wait_nxt = '0;
        else if (wr0_req || wr1_req)
            wait_nxt = sat_inc(wait_cnt);
    end

    // Stage p0: grant registered onto the RAM port
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            wr0_ack   <= 1'b0;
            wr1_ack   <= 1'b0;
            rr_ptr    <= 1'b0;
            wait_cnt  <= '0;
            starve    <= 1'b0;
            vld_p0    <= 1'b0;
        end else begin
            wr0_ack  <= wr0_gnt;
            wr1_ack  <= wr1_gnt;
            mem_we   <= wr0_gnt || wr1_gnt;
            wait_cnt <= wait_nxt;
            starve   <= (wait_nxt == WAIT_MAX);
            vld_p0   <= rd_req;
            if (rd_req) begin
                mem_addr <= rd_addr;
            end else if (wr0_gnt) begin
                mem_addr  <= wr0_addr;
                mem_wdata <= wr0_data;
                rr_ptr    <= 1'b1;
            end else if (wr1_gnt) begin
                mem_addr  <= wr1_addr;
                mem_wdata <= wr1_data;
                rr_ptr    <= 1'b0;
            end
        end
    end

    // Stage p1: RAM registers its read data; stage p2: pixel captured for scan-out
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1   <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            vld_p1   <= vld_p0;
            rd_valid <= vld_p1;
            if (vld_p1)
                rd_data <= mem_rdata;
        end
    end

endmodule
